block_sram_writer: RTL

BLOCK_SRAM_WRITER -- requirements
Module: block_sram_writer

---
 rtl/block_sram_writer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/block_sram_writer.sv
// block_sram_writer: streams one BLOCK_DIM x BLOCK_DIM block of signed samples
// out of a dual-port RAM. Each sample is clipped to 8 bits, and pairs of samples
// are packed into 16-bit words. The words are written to the block's place in a
// planar Y/U/V frame in SRAM. The block position advances after every block and
// walks Y, then U, then V, then wraps back to Y (0,0).
//
// Handshake: WS_start is a one-cycle request and is honoured only in IDLE.
// WS_done is a one-cycle completion pulse. No backpressure exists on either side.
// ram_read_data belongs to the ram_address issued one cycle earlier.
module block_sram_writer #(
  parameter int BLOCK_DIM     = 8,
  parameter int Y_BLOCK_COLS  = 40,
  parameter int UV_BLOCK_COLS = 20,
  parameter int BLOCK_ROWS    = 30,
  parameter int U_BASE        = 38400,
  parameter int V_BASE        = 57600
) (
  input  logic                               CLOCK_50_I,
  input  logic                               Resetn,
  input  logic                               WS_start,
  input  logic                               pos_clear,
  output logic [2*$clog2(BLOCK_DIM)-1:0]     ram_address,
  input  logic [15:0]                        ram_read_data,
  output logic [17:0]                        SRAM_address,
  output logic                               SRAM_we_n,
  output logic [15:0]                        SRAM_write_data,
  output logic                               WS_done,
  output logic                               all_done,
  output logic [2:0]                         o_dbg_state
);

  localparam int LOG_BD = $clog2(BLOCK_DIM);
  localparam int AW     = 2 * LOG_BD;

  localparam logic [2:0] S_WS_IDLE = 3'd0;
  localparam logic [2:0] S_WS_LEAD = 3'd1;
  localparam logic [2:0] S_WS_RUN  = 3'd2;
  localparam logic [2:0] S_WS_TAIL = 3'd3;
  localparam logic [2:0] S_WS_DONE = 3'd4;

  localparam logic [1:0] PL_Y = 2'd0;
  localparam logic [1:0] PL_U = 2'd1;
  localparam logic [1:0] PL_V = 2'd2;

  localparam logic [AW-1:0]     K_LAST = AW'(BLOCK_DIM * BLOCK_DIM - 1);
  localparam logic [LOG_BD-1:0] C_LAST = LOG_BD'(BLOCK_DIM - 1);

  // Words per SRAM row and words per block row for each plane. These values are
  // elaboration-time constants, so the per-cycle path has only adders.
  localparam logic [17:0] Y_ROW_W    = 18'(Y_BLOCK_COLS * BLOCK_DIM / 2);
  localparam logic [17:0] UV_ROW_W   = 18'(UV_BLOCK_COLS * BLOCK_DIM / 2);
  localparam logic [17:0] Y_BLK_ROW  = 18'(Y_BLOCK_COLS * BLOCK_DIM * BLOCK_DIM / 2);
  localparam logic [17:0] UV_BLK_ROW = 18'(UV_BLOCK_COLS * BLOCK_DIM * BLOCK_DIM / 2);
  localparam logic [17:0] BLK_HALF   = 18'(BLOCK_DIM / 2);
  localparam logic [17:0] U_BASE_A   = 18'(U_BASE);
  localparam logic [17:0] V_BASE_A   = 18'(V_BASE);

  localparam logic [15:0] Y_COLS_M1  = 16'(Y_BLOCK_COLS - 1);
  localparam logic [15:0] UV_COLS_M1 = 16'(UV_BLOCK_COLS - 1);
  localparam logic [15:0] ROWS_M1    = 16'(BLOCK_ROWS - 1);

  logic [2:0]        r_state;
  logic [AW-1:0]     r_ram_addr;
  logic [AW-1:0]     r_cap_k;
  logic [7:0]        r_even;
  logic [17:0]       r_row_addr;
  logic [17:0]       r_sram_addr;
  logic              r_we_n;
  logic [15:0]       r_wdata;
  logic              r_ws_done;
  logic              r_all_done;

  // Block position: plane, block column, block row, and two running bases
  // (the start of the current block row and the top-left word of the block).
  logic [1:0]        r_plane;
  logic [15:0]       r_cb;
  logic [15:0]       r_rb;
  logic [17:0]       r_rowblk_base;
  logic [17:0]       r_blk_base;

  logic [7:0]        w_clip;
  logic              w_cap;
  logic [LOG_BD-1:0] w_c;
  logic              w_col_last;
  logic [17:0]       w_row_w;
  logic [17:0]       w_blk_row;
  logic [15:0]       w_cols_m1;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_last_block;

  // Saturate the signed sample into the 0..255 range.
  always_comb begin
    w_clip = ram_read_data[7:0];
    if (ram_read_data[15])
      w_clip = 8'd0;
    else if (|ram_read_data[14:8])
      w_clip = 8'hFF;
  end

  // Every RUN cycle and the TAIL cycle present a valid sample for element r_cap_k.
  assign w_cap        = (r_state == S_WS_RUN) || (r_state == S_WS_TAIL);
  assign w_c          = r_cap_k[LOG_BD-1:0];
  assign w_col_last   = (w_c == C_LAST);
  assign w_row_w      = (r_plane == PL_Y) ? Y_ROW_W   : UV_ROW_W;
  assign w_blk_row    = (r_plane == PL_Y) ? Y_BLK_ROW : UV_BLK_ROW;
  assign w_cols_m1    = (r_plane == PL_Y) ? Y_COLS_M1 : UV_COLS_M1;
  assign w_last_col   = (r_cb == w_cols_m1);
  assign w_last_row   = (r_rb == ROWS_M1);
  assign w_last_block = (r_plane == PL_V) && w_last_col && w_last_row;

  // Sequencer: issue RAM addresses, capture samples, pack pairs, and write to SRAM.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_WS_IDLE;
      r_ram_addr  <= '0;
      r_cap_k     <= '0;
      r_even      <= 8'd0;
      r_row_addr  <= 18'd0;
      r_sram_addr <= 18'd0;
      r_we_n      <= 1'b1;
      r_wdata     <= 16'd0;
      r_ws_done   <= 1'b0;
      r_all_done  <= 1'b0;
    end else begin
      r_we_n     <= 1'b1;
      r_ws_done  <= 1'b0;
      r_all_done <= 1'b0;
      case (r_state)
        S_WS_IDLE: begin
          if (WS_start) begin
            r_ram_addr <= '0;
            r_cap_k    <= '0;
            // A simultaneous pos_clear redirects this block to Y (0,0).
            r_row_addr <= pos_clear ? 18'd0 : r_blk_base;
            r_state    <= S_WS_LEAD;
          end
        end
        S_WS_LEAD: begin
          r_ram_addr <= r_ram_addr + 1'b1;
          r_state    <= S_WS_RUN;
        end
        S_WS_RUN: begin
          if (r_ram_addr == K_LAST)
            r_state <= S_WS_TAIL;
          else
            r_ram_addr <= r_ram_addr + 1'b1;
        end
        S_WS_TAIL: begin
          r_state    <= S_WS_DONE;
          r_ws_done  <= 1'b1;
          r_all_done <= w_last_block;
        end
        S_WS_DONE: begin
          r_state <= S_WS_IDLE;
        end
        default: begin
          r_state <= S_WS_IDLE;
        end
      endcase

      if (w_cap) begin
        r_cap_k <= r_cap_k + 1'b1;
        if (!r_cap_k[0]) begin
          r_even <= w_clip;
        end else begin
          r_we_n      <= 1'b0;
          r_wdata     <= {r_even, w_clip};
          r_sram_addr <= r_row_addr + 18'(w_c >> 1);
          if (w_col_last)
            r_row_addr <= r_row_addr + w_row_w;
        end
      end
    end
  end

  // Position tracker: clear in IDLE, advance column/row/plane as each block retires.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_plane       <= PL_Y;
      r_cb          <= 16'd0;
      r_rb          <= 16'd0;
      r_rowblk_base <= 18'd0;
      r_blk_base    <= 18'd0;
    end else if ((r_state == S_WS_IDLE) && pos_clear) begin
      r_plane       <= PL_Y;
      r_cb          <= 16'd0;
      r_rb          <= 16'd0;
      r_rowblk_base <= 18'd0;
      r_blk_base    <= 18'd0;
    end else if (r_state == S_WS_DONE) begin
      if (!w_last_col) begin
        r_cb       <= r_cb + 16'd1;
        r_blk_base <= r_blk_base + BLK_HALF;
      end else if (!w_last_row) begin
        r_cb          <= 16'd0;
        r_rb          <= r_rb + 16'd1;
        r_rowblk_base <= r_rowblk_base + w_blk_row;
        r_blk_base    <= r_rowblk_base + w_blk_row;
      end else begin
        r_cb <= 16'd0;
        r_rb <= 16'd0;
        case (r_plane)
          PL_Y: begin
            r_plane       <= PL_U;
            r_rowblk_base <= U_BASE_A;
            r_blk_base    <= U_BASE_A;
          end
          PL_U: begin
            r_plane       <= PL_V;
            r_rowblk_base <= V_BASE_A;
            r_blk_base    <= V_BASE_A;
          end
          default: begin
            r_plane       <= PL_Y;
            r_rowblk_base <= 18'd0;
            r_blk_base    <= 18'd0;
          end
        endcase
      end
    end
  end

  assign ram_address     = r_ram_addr;
  assign SRAM_address    = r_sram_addr;
  assign SRAM_we_n       = r_we_n;
  assign SRAM_write_data = r_wdata;
  assign WS_done         = r_ws_done;
  assign all_done        = r_all_done;
  assign o_dbg_state     = r_state;

endmodule
